// File: rtl/rstack_ctrl.sv
// Return-stack controller: owns sp/count, drives a 1R1W async-read memory and
// exposes top-of-stack combinationally; overflow/underflow freeze it in ERR until cleared.
module rstack_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  err,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  we,
  output logic [WIDTH-1:0]      mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  typedef enum logic {RUN, ERR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sp, sp_nxt;
  logic [WIDTH:0]   count, count_nxt;
  logic             overflow_nxt, underflow_nxt;

  // sp points at the next free slot, so the top entry always lives at sp-1.
  assign mem_dout_addr = sp - WIDTH'(1);
  assign empty         = (count == '0);
  assign full          = (count == (WIDTH+1)'(SIZE));
  assign err           = (state == ERR);
  assign top           = empty ? '0 : mem_dout;

  always_comb begin
    state_nxt     = state;
    sp_nxt        = sp;
    count_nxt     = count;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    we            = 1'b0;
    mem_din_addr  = sp;
    mem_din       = push_data;

    case (state)
      RUN: begin
        if (clear_err) begin
          overflow_nxt  = 1'b0;
          underflow_nxt = 1'b0;
        end
        if (push && pop) begin
          if (empty) begin
            underflow_nxt = 1'b1;
            state_nxt     = ERR;
          end else begin
            // Replace-top: legal even when full since occupancy does not change.
            we           = 1'b1;
            mem_din_addr = sp - WIDTH'(1);
          end
        end else if (push) begin
          if (full) begin
            overflow_nxt = 1'b1;
            state_nxt    = ERR;
          end else begin
            we        = 1'b1;
            sp_nxt    = sp + WIDTH'(1);
            count_nxt = count + (WIDTH+1)'(1);
          end
        end else if (pop) begin
          if (empty) begin
            underflow_nxt = 1'b1;
            state_nxt     = ERR;
          end else begin
            sp_nxt    = sp - WIDTH'(1);
            count_nxt = count - (WIDTH+1)'(1);
          end
        end
      end
      ERR: begin
        if (clear_err) begin
          overflow_nxt  = 1'b0;
          underflow_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      sp        <= sp_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_rstack_ctrl.sv
// Directed bench for rstack_ctrl with a behavioural return-stack memory;
// expected cycle responses are queued by the driver and checked by a monitor.
module tb_rstack_ctrl;

  logic        clk = 1'b0;
  logic        rst, push, pop, clear_err;
  logic [12:0] push_data, top, mem_dout, mem_din;
  logic        empty, full, overflow, underflow, err, we;
  logic [3:0]  mem_dout_addr, mem_din_addr;

  always #5 clk = ~clk;

  rstack_ctrl #(.WIDTH(4), .SIZE(16), .DATA_WIDTH(13)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .top(top), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .err(err),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .we(we),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  logic [12:0] mem [16];
  assign mem_dout = mem[mem_dout_addr];
  always @(posedge clk) if (we) mem[mem_din_addr] <= mem_din;

  typedef struct packed {
    logic        we;
    logic [3:0]  waddr;
    logic [12:0] wdata;
    logic [12:0] top;
    logic        empty, full, ovf, unf, err;
    logic [3:0]  raddr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  mon_en = 1'b0;
  int    checks = 0;
  int    failures = 0;

  function automatic exp_t mk(logic w, logic [3:0] wa, logic [12:0] wd, logic [12:0] t,
                              logic e, logic f, logic o, logic u, logic er, logic [3:0] ra);
    exp_t x;
    x.we = w; x.waddr = w ? wa : 4'd0; x.wdata = w ? wd : 13'd0;
    x.top = t; x.empty = e; x.full = f; x.ovf = o; x.unf = u; x.err = er; x.raddr = ra;
    return x;
  endfunction

  task automatic step(input logic p, input logic po, input logic [12:0] d, input logic c,
                      input logic r, input logic chk, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    push = p; pop = po; push_data = d; clear_err = c; rst = r;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    mon_en = chk;
  endtask

  // Monitor: samples mid-cycle and retires one queued expectation per checked cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t  a, e;
      string nm;
      a.we = we; a.waddr = we ? mem_din_addr : 4'd0; a.wdata = we ? mem_din : 13'd0;
      a.top = top; a.empty = empty; a.full = full; a.ovf = overflow; a.unf = underflow;
      a.err = err; a.raddr = mem_dout_addr;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: DUT cycle with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got we=%b wa=%h wd=%h top=%h e/f/o/u/err=%b%b%b%b%b ra=%h; expected we=%b wa=%h wd=%h top=%h e/f/o/u/err=%b%b%b%b%b ra=%h",
                   nm, a.we, a.waddr, a.wdata, a.top, a.empty, a.full, a.ovf, a.unf, a.err, a.raddr,
                   e.we, e.waddr, e.wdata, e.top, e.empty, e.full, e.ovf, e.unf, e.err, e.raddr);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 13'h000;
    push = 0; pop = 0; push_data = 0; clear_err = 0; rst = 1;
    step(0, 0, 0, 0, 1, 0, '0, "");
    step(0, 0, 0, 0, 1, 0, '0, "");

    // Basic push / pop
    step(1, 0, 13'h100, 0, 0, 1, mk(1, 4'h0, 13'h100, 13'h000, 1, 0, 0, 0, 0, 4'hF), "reset_push0");
    step(1, 0, 13'h101, 0, 0, 1, mk(1, 4'h1, 13'h101, 13'h100, 0, 0, 0, 0, 0, 4'h0), "push1");
    step(1, 0, 13'h102, 0, 0, 1, mk(1, 4'h2, 13'h102, 13'h101, 0, 0, 0, 0, 0, 4'h1), "push2");
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'h102, 0, 0, 0, 0, 0, 4'h2), "pop_top102");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h101, 0, 0, 0, 0, 0, 4'h1), "after_pop1");
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'h101, 0, 0, 0, 0, 0, 4'h1), "pop2");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h100, 0, 0, 0, 0, 0, 4'h0), "after_pop2");
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'h100, 0, 0, 0, 0, 0, 4'h0), "pop3");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "empty_again");

    // Fill to 16 entries, sp wraps to 0
    for (int i = 0; i < 16; i++)
      step(1, 0, 13'(i), 0, 0, 1,
           mk(1, 4'(i), 13'(i), (i == 0) ? 13'd0 : 13'(i - 1), i == 0, 0, 0, 0, 0, 4'(i - 1)), "fill");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 0, 0, 0, 4'hF), "full_wrap");
    step(1, 0, 13'h1FF, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 0, 0, 0, 4'hF), "push_when_full");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 1, 0, 1, 4'hF), "overflow_err");
    step(1, 0, 13'h055, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 1, 0, 1, 4'hF), "err_push_ignored");
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 1, 0, 1, 4'hF), "err_pop_ignored");
    step(1, 1, 13'h066, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 1, 0, 1, 4'hF), "err_pushpop_ignored");
    step(0, 0, 0, 1, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 1, 0, 1, 4'hF), "clear_err_cycle");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'd15, 0, 1, 0, 0, 0, 4'hF), "cleared_full");

    // Replace-top while full
    step(1, 1, 13'h0AA, 0, 0, 1, mk(1, 4'hF, 13'h0AA, 13'd15, 0, 1, 0, 0, 0, 4'hF), "replace_full");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h0AA, 0, 1, 0, 0, 0, 4'hF), "replace_full_after");

    // Reset wins over a simultaneous push
    step(1, 0, 13'h077, 0, 1, 1, mk(0, 0, 0, 13'h0AA, 0, 1, 0, 0, 0, 4'hF), "rst_with_push");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "after_rst");

    // Pop on empty
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "pop_empty");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 1, 1, 4'hF), "underflow_err");
    step(0, 0, 0, 1, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 1, 1, 4'hF), "clear_unf_cycle");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "unf_cleared");

    // Replace-top with two entries
    step(1, 0, 13'h010, 0, 0, 1, mk(1, 4'h0, 13'h010, 13'h000, 1, 0, 0, 0, 0, 4'hF), "push_010");
    step(1, 0, 13'h020, 0, 0, 1, mk(1, 4'h1, 13'h020, 13'h010, 0, 0, 0, 0, 0, 4'h0), "push_020");
    step(1, 1, 13'h0AA, 0, 0, 1, mk(1, 4'h1, 13'h0AA, 13'h020, 0, 0, 0, 0, 0, 4'h1), "replace_top");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h0AA, 0, 0, 0, 0, 0, 4'h1), "replace_after");
    step(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 13'h0AA, 0, 0, 0, 0, 0, 4'h1), "pop_after_replace");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h010, 0, 0, 0, 0, 0, 4'h0), "count_kept_2");

    // Push&pop on empty
    step(0, 0, 0, 0, 1, 1, mk(0, 0, 0, 13'h010, 0, 0, 0, 0, 0, 4'h0), "rst_again");
    step(1, 1, 13'h033, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "pushpop_empty");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 1, 1, 4'hF), "pushpop_empty_err");
    step(0, 0, 0, 0, 1, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 1, 1, 4'hF), "rst_in_err");
    step(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 13'h000, 1, 0, 0, 0, 0, 4'hF), "rst_clears_err");

    step(0, 0, 0, 0, 0, 0, '0, "");
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
